// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: nibble-to-glyph lookup (active-low {a,b,c,d,e,f,g}) and the all-segments-off constant
package sevenseg_pkg;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'ha: glyph = 7'b0001000;
      4'hb: glyph = 7'b1100000;
      4'hc: glyph = 7'b0110001;
      4'hd: glyph = 7'b1000010;
      4'he: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction
endpackage

// File: rtl/sevenseg_tick_gen.sv
// sevenseg_tick_gen: prescaler giving a one-cycle tick every CLK_DIV clocks; ports clk, rst_n -> tick
module sevenseg_tick_gen #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed 7-seg scanner with LZ blanking, PWM dimming, frame-synchronous updates; ports clk, rst_n, value, dp_mask, load, blank_lz, brightness -> an, sev_out, dp_out, frame_done
module sevenseg_scan import sevenseg_pkg::*; #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 1000,
  parameter int PWM_BITS       = 4,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              sev_out,
  output logic                    dp_out,
  output logic                    frame_done
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0] SEG_INV = {7{!SEG_ACTIVE_LOW}};
  localparam logic DP_INV = !SEG_ACTIVE_LOW;
  logic tick, wrap, pend_new, lit, dp_lo;
  logic [IW-1:0] idx, lz_limit, lz_next;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [4*NUM_DIGITS-1:0] pend_val, disp_val;
  logic [NUM_DIGITS-1:0] pend_dp, disp_dp, an_hi;
  logic [6:0] seg_lo;
  sevenseg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );
  assign wrap = tick && idx == IW'(NUM_DIGITS - 1);
  always_comb begin
    lz_next = '0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (pend_val[4*i +: 4] != 4'h0) lz_next = IW'(i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx        <= '0;
      pwm_cnt    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_new   <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      lz_limit   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (tick) idx <= wrap ? '0 : idx + 1'b1;
      pwm_cnt    <= pwm_cnt + 1'b1;
      frame_done <= wrap;
      if (wrap && pend_new) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
        lz_limit <= lz_next;
      end
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_mask;
      end
      pend_new <= load || (pend_new && !wrap);
    end
  assign lit    = !(blank_lz && idx > lz_limit) && (&brightness || pwm_cnt < brightness);
  assign an_hi  = lit ? NUM_DIGITS'(1) << idx : '0;
  assign seg_lo = lit ? glyph(disp_val[{idx, 2'b00} +: 4]) : SEG_OFF;
  assign dp_lo  = lit ? !disp_dp[idx] : 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      an      <= AN_OFF;
      sev_out <= SEG_OFF ^ SEG_INV;
      dp_out  <= 1'b1 ^ DP_INV;
    end else begin
      an      <= an_hi ^ AN_OFF;
      sev_out <= seg_lo ^ SEG_INV;
      dp_out  <= dp_lo ^ DP_INV;
    end
endmodule
